// File: rtl/generador_cubos_pkg.sv
// Shared types and constants for the falling-cubes spawn controller.
package generador_cubos_pkg;

   localparam int X_W = 9;
   localparam int V_W = 2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      SORTEO,
      LANZAR,
      ESPERA
   } estado_t;

   // One step of the right-shifting Galois LFSR; never maps a non-zero value to zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
   endfunction

endpackage

// File: rtl/generador_aleatorio_cubos_lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
module lfsr16
   import generador_cubos_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] q
);

   // Advance the sequence on every clock, whatever the controller is doing.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= LFSR_SEED;
      else       q <= lfsr_step(q);
   end

endmodule

// File: rtl/generador_aleatorio_cubos.sv
// Spawn controller: draws a start column and fall speed per cube, strobes the
// launch, then waits for the cube to finish before drawing the next one.
module generador_aleatorio_cubos
   import generador_cubos_pkg::*;
#(
   parameter int X_MIN           = 16,
   parameter int X_MAX           = 464,
   parameter int CUBOS_POR_NIVEL = 8,
   parameter int MAX_INTENTOS    = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             terminado_cubo,
   output logic [X_W-1:0]   posicion_x_inicial_aleatoria,
   output logic [V_W-1:0]   velocidad_cubo,
   output logic             lanzar_cubo,
   output logic [7:0]       cubos_lanzados
);

   // Column range and the fallback offset, all in 9-bit modular arithmetic.
   // The fallback X_MIN + c - (R+1) is always in 0..511, so wrapping is exact.
   localparam logic [X_W-1:0] X_MIN_P     = X_W'(X_MIN);
   localparam logic [X_W-1:0] RANGO_P     = X_W'(X_MAX - X_MIN);
   localparam logic [X_W-1:0] OFFSET_FB_P = X_W'(X_MIN - (X_MAX - X_MIN + 1));
   localparam logic [7:0]     MAX_I       = 8'(MAX_INTENTOS);
   localparam logic [2:0]     CPN_ULTIMO  = 3'(CUBOS_POR_NIVEL - 1);

   logic [15:0]    lfsr_q;
   estado_t        estado_q, estado_d;
   logic           start_prev;
   logic [7:0]     intentos_q;
   logic [2:0]     cuenta_nivel_q;
   logic [V_W-1:0] nivel_q;

   logic           cargar, usar_fallback, incr_intento;
   logic [X_W-1:0] candidato, posicion_d;
   logic [V_W-1:0] v_cruda, velocidad_d;
   logic           acepta_directo;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   // The LFSR can never lock up at zero; a zero would mean a corrupted register.
   lfsr_nunca_cero: assert property (@(posedge clk) disable iff (reset) lfsr_q != 16'd0);

   // Candidate column and speed derived from the current LFSR value.
   always_comb begin
      candidato      = lfsr_q[X_W-1:0];
      acepta_directo = (candidato <= RANGO_P);
      posicion_d     = usar_fallback ? (candidato + OFFSET_FB_P) : (candidato + X_MIN_P);
      v_cruda        = (lfsr_q[10:9] == 2'd0) ? 2'd1 : lfsr_q[10:9];
      velocidad_d    = (v_cruda > nivel_q) ? v_cruda : nivel_q;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado_q <= IDLE;
      else       estado_q <= estado_d;
   end

   // Next-state logic and Moore launch strobe.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      estado_d      = estado_q;
      cargar        = 1'b0;
      usar_fallback = 1'b0;
      incr_intento  = 1'b0;
      lanzar_cubo   = 1'b0;
      unique case (estado_q)
         IDLE:   if (start && !start_prev) estado_d = SORTEO;
         SORTEO: begin
            if (acepta_directo) begin
               cargar   = 1'b1;
               estado_d = LANZAR;
            end else if (intentos_q == MAX_I) begin
               cargar        = 1'b1;
               usar_fallback = 1'b1;
               estado_d      = LANZAR;
            end else begin
               incr_intento = 1'b1;
            end
         end
         LANZAR: begin
            lanzar_cubo = 1'b1;
            estado_d    = ESPERA;
         end
         ESPERA: if (terminado_cubo) estado_d = SORTEO;
         default: estado_d = IDLE;
      endcase
   end

   // Edge detector, retry counter, held outputs, launch counter and speed floor.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_prev                   <= 1'b0;
         intentos_q                   <= 8'd0;
         posicion_x_inicial_aleatoria <= X_MIN_P;
         velocidad_cubo               <= 2'd1;
         cubos_lanzados               <= 8'd0;
         cuenta_nivel_q               <= 3'd0;
         nivel_q                      <= 2'd1;
      end else begin
         start_prev <= start;
         if (cargar) begin
            posicion_x_inicial_aleatoria <= posicion_d;
            velocidad_cubo               <= velocidad_d;
            intentos_q                   <= 8'd0;
         end else if (incr_intento) begin
            intentos_q <= intentos_q + 8'd1;
         end
         if (estado_q == LANZAR) begin
            cubos_lanzados <= cubos_lanzados + 8'd1;
            if (cuenta_nivel_q == CPN_ULTIMO) begin
               cuenta_nivel_q <= 3'd0;
               if (nivel_q != 2'd3) nivel_q <= nivel_q + 2'd1;
            end else begin
               cuenta_nivel_q <= cuenta_nivel_q + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_generador_aleatorio_cubos.sv
// Randomised bench for the spawn controller, with a draw-level reference model.
module tb_generador_aleatorio_cubos;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] TAPS = 16'hB400;
   localparam int          CPN  = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, terminado = 1'b0;
   logic       start2 = 1'b0, term2 = 1'b0;
   logic [8:0] pos1, pos2;
   logic [1:0] vel1, vel2;
   logic       lanz1, lanz2;
   logic [7:0] cub1, cub2;

   int checks = 0;
   int errors = 0;

   generador_aleatorio_cubos #(
      .X_MIN(16), .X_MAX(464), .CUBOS_POR_NIVEL(8), .MAX_INTENTOS(8)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .terminado_cubo(terminado),
      .posicion_x_inicial_aleatoria(pos1), .velocidad_cubo(vel1),
      .lanzar_cubo(lanz1), .cubos_lanzados(cub1)
   );

   generador_aleatorio_cubos #(
      .X_MIN(0), .X_MAX(255), .CUBOS_POR_NIVEL(8), .MAX_INTENTOS(0)
   ) u_fb (
      .clk(clk), .reset(reset), .start(start2), .terminado_cubo(term2),
      .posicion_x_inicial_aleatoria(pos2), .velocidad_cubo(vel2),
      .lanzar_cubo(lanz2), .cubos_lanzados(cub2)
   );

   always #5 clk = ~clk;

   // Random source model: hist[e] is the LFSR value seen by the design at edge e after reset.
   logic [15:0] m_lfsr;
   int          cyc;
   logic [15:0] hist [0:16383];

   function automatic logic [15:0] nxt(input logic [15:0] s);
      return (s % 2 == 1) ? ((s / 2) ^ TAPS) : (s / 2);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_lfsr <= SEED;
         cyc    <= 0;
      end else begin
         hist[cyc] <= m_lfsr;
         m_lfsr    <= nxt(m_lfsr);
         cyc       <= cyc + 1;
      end
   end

   // Draw model: the draw starts at edge k; tries happen at edges k+1, k+2, ...
   function automatic void predict(input int k, input int xmin, input int xmax, input int maxi,
                                   input int nprev, output int a, output int pos, output int vel);
      int r, c, v, fl;
      bit done;
      r = xmax - xmin;
      done = 1'b0;
      a = k + 1;
      pos = xmin;
      for (int t = 0; t <= maxi && !done; t++) begin
         c = int'(hist[k + 1 + t][8:0]);
         a = k + 1 + t;
         if (c <= r) begin
            pos = xmin + c;
            done = 1'b1;
         end else if (t == maxi) begin
            pos = xmin + c - (r + 1);
            done = 1'b1;
         end
      end
      v = int'(hist[a][10:9]);
      if (v == 0) v = 1;
      fl = 1 + nprev / CPN;
      if (fl > 3) fl = 3;
      vel = (v > fl) ? v : fl;
   endfunction

   task automatic wait_strobe(input bit inst, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if ((inst ? lanz2 : lanz1) === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; terminado = 1'b0; start2 = 1'b0; term2 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int highs;
      do_reset();
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (lanz1 !== 1'b0 || lanz2 !== 1'b0) highs++;
      end
      checks++; if (highs !== 0) begin errors++; $display("FAIL reset_strobe: got %0d strobes expected 0", highs); end
      checks++; if (pos1 !== 9'd16) begin errors++; $display("FAIL reset_pos: got %0d expected 16", pos1); end
      checks++; if (vel1 !== 2'd1) begin errors++; $display("FAIL reset_vel: got %0d expected 1", vel1); end
      checks++; if (cub1 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cub1); end
      checks++; if (pos2 !== 9'd0) begin errors++; $display("FAIL reset_pos_fb: got %0d expected 0", pos2); end
   endtask

   task automatic test_main_launches();
      int k, n, a, p, v;
      bit ok;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      k = cyc;
      n = 0;
      for (int l = 1; l <= 300; l++) begin
         wait_strobe(1'b0, 15, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL main_timeout: launch %0d got none expected strobe", l); return; end
         predict(k, 16, 464, 8, n, a, p, v);
         checks++; if (cyc - 1 !== a) begin errors++; $display("FAIL main_timing: launch %0d edge %0d expected %0d", l, cyc - 1, a); end
         checks++; if (pos1 !== 9'(p)) begin errors++; $display("FAIL main_pos: launch %0d got %0d expected %0d", l, pos1, p); end
         checks++; if (vel1 !== 2'(v)) begin errors++; $display("FAIL main_vel: launch %0d got %0d expected %0d", l, vel1, v); end
         checks++; if (pos1 < 9'd16 || pos1 > 9'd464) begin errors++; $display("FAIL main_range: launch %0d got %0d expected 16..464", l, pos1); end
         checks++; if (vel1 === 2'd0) begin errors++; $display("FAIL main_vel_zero: launch %0d got 0 expected 1..3", l); end
         if (l >= 17) begin
            checks++; if (vel1 !== 2'd3) begin errors++; $display("FAIL floor3: launch %0d got %0d expected 3", l, vel1); end
         end else if (l >= 9) begin
            checks++; if (vel1 < 2'd2) begin errors++; $display("FAIL floor2: launch %0d got %0d expected >=2", l, vel1); end
         end
         checks++; if (cub1 !== 8'(n)) begin errors++; $display("FAIL main_count_pre: launch %0d got %0d expected %0d", l, cub1, n % 256); end
         @(negedge clk);
         n++;
         checks++; if (lanz1 !== 1'b0) begin errors++; $display("FAIL main_strobe_len: launch %0d got %0d expected 0", l, lanz1); end
         checks++; if (cub1 !== 8'(n)) begin errors++; $display("FAIL main_count_post: launch %0d got %0d expected %0d", l, cub1, n % 256); end
         checks++; if (pos1 !== 9'(p)) begin errors++; $display("FAIL main_hold: launch %0d got %0d expected %0d", l, pos1, p); end
         repeat (2) @(negedge clk);
         terminado = 1'b1;
         k = cyc;
         @(negedge clk);
         terminado = 1'b0;
      end
      checks++; if (cub1 !== 8'd44) begin errors++; $display("FAIL main_final_count: got %0d expected 44", cub1); end
   endtask

   task automatic test_back_to_back();
      int k, n, a, p, v, prev_a;
      bit ok;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      terminado = 1'b1;
      k = cyc;
      n = 0;
      prev_a = -1;
      for (int l = 1; l <= 40; l++) begin
         wait_strobe(1'b0, 15, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL b2b_timeout: launch %0d got none expected strobe", l); return; end
         predict(k, 16, 464, 8, n, a, p, v);
         checks++; if (cyc - 1 !== a) begin errors++; $display("FAIL b2b_timing: launch %0d edge %0d expected %0d", l, cyc - 1, a); end
         if (prev_a >= 0 && a == k + 1) begin
            checks++; if (cyc - 1 - prev_a !== 3) begin errors++; $display("FAIL b2b_period: launch %0d got %0d expected 3", l, cyc - 1 - prev_a); end
         end
         checks++; if (pos1 !== 9'(p)) begin errors++; $display("FAIL b2b_pos: launch %0d got %0d expected %0d", l, pos1, p); end
         checks++; if (vel1 !== 2'(v)) begin errors++; $display("FAIL b2b_vel: launch %0d got %0d expected %0d", l, vel1, v); end
         checks++; if (cub1 !== 8'(n)) begin errors++; $display("FAIL b2b_count: launch %0d got %0d expected %0d", l, cub1, n); end
         start = 1'($urandom_range(0, 1));
         prev_a = a;
         k = a + 2;
         n++;
      end
      terminado = 1'b0;
   endtask

   task automatic test_fallback();
      int k, n, a, p, v, ep;
      bit ok;
      do_reset();
      @(negedge clk);
      start2 = 1'b1;
      term2 = 1'b1;
      k = cyc;
      n = 0;
      for (int l = 1; l <= 30; l++) begin
         wait_strobe(1'b1, 6, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL fb_timeout: launch %0d got none expected strobe", l); return; end
         ep = int'(hist[k + 1][8:0]) % 256;
         predict(k, 0, 255, 0, n, a, p, v);
         checks++; if (cyc - 1 !== k + 1) begin errors++; $display("FAIL fb_timing: launch %0d edge %0d expected %0d", l, cyc - 1, k + 1); end
         checks++; if (pos2 !== 9'(ep)) begin errors++; $display("FAIL fb_pos: launch %0d got %0d expected %0d", l, pos2, ep); end
         checks++; if (vel2 !== 2'(v)) begin errors++; $display("FAIL fb_vel: launch %0d got %0d expected %0d", l, vel2, v); end
         checks++; if (cub2 !== 8'(n)) begin errors++; $display("FAIL fb_count: launch %0d got %0d expected %0d", l, cub2, n); end
         k = k + 3;
         n++;
      end
      term2 = 1'b0;
   endtask

   task automatic test_reset_mid_espera();
      int k, n, a, p, v, highs;
      bit ok;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      k = cyc;
      n = 0;
      for (int l = 1; l <= 5; l++) begin
         wait_strobe(1'b0, 15, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL mid_timeout: launch %0d got none expected strobe", l); return; end
         predict(k, 16, 464, 8, n, a, p, v);
         checks++; if (pos1 !== 9'(p)) begin errors++; $display("FAIL mid_pos: launch %0d got %0d expected %0d", l, pos1, p); end
         n++;
         if (l < 5) begin
            repeat (3) @(negedge clk);
            terminado = 1'b1;
            k = cyc;
            @(negedge clk);
            terminado = 1'b0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      checks++; if (cub1 !== 8'd5) begin errors++; $display("FAIL mid_count5: got %0d expected 5", cub1); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (pos1 !== 9'd16) begin errors++; $display("FAIL mid_reset_pos: got %0d expected 16", pos1); end
      checks++; if (vel1 !== 2'd1) begin errors++; $display("FAIL mid_reset_vel: got %0d expected 1", vel1); end
      checks++; if (cub1 !== 8'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", cub1); end
      checks++; if (lanz1 !== 1'b0) begin errors++; $display("FAIL mid_reset_strobe: got %0d expected 0", lanz1); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (lanz1 !== 1'b0) highs++;
      end
      checks++; if (highs !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d strobes expected 0", highs); end
      start = 1'b1;
      k = cyc;
      n = 0;
      for (int l = 1; l <= 2; l++) begin
         wait_strobe(1'b0, 15, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL mid_restart_timeout: launch %0d got none expected strobe", l); return; end
         predict(k, 16, 464, 8, n, a, p, v);
         checks++; if (cyc - 1 !== a) begin errors++; $display("FAIL mid_restart_timing: launch %0d edge %0d expected %0d", l, cyc - 1, a); end
         checks++; if (pos1 !== 9'(p)) begin errors++; $display("FAIL mid_restart_pos: launch %0d got %0d expected %0d", l, pos1, p); end
         @(negedge clk);
         n++;
         checks++; if (cub1 !== 8'(n)) begin errors++; $display("FAIL mid_restart_count: launch %0d got %0d expected %0d", l, cub1, n); end
         repeat (2) @(negedge clk);
         terminado = 1'b1;
         k = cyc;
         @(negedge clk);
         terminado = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_main_launches();
      test_back_to_back();
      test_fallback();
      test_reset_mid_espera();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/generador_aleatorio_cubos.md
# generador_aleatorio_cubos

Upstream spawn controller for the falling-cubes game. It replaces the hard-wired start position and speed currently fed to `Cubo` with a pseudo-random 9-bit start column and a 2-bit fall speed per cube. It issues one launch pulse per cube and waits for the cube's completion before drawing the next. A launch counter raises the minimum speed as play progresses. Sits between the top-level `start` input, `Cubo` (drives `posicion_x_inicial_aleatoria` and `velocidad_cubo_in`; consumes `terminadoCubo`) and any score logic.

## Interface

Parameters:
- `X_MIN`, 16: leftmost legal start column.
- `X_MAX`, 464: rightmost legal start column. Constraint: `X_MAX - X_MIN` ≥ 255 and `X_MAX` ≤ 511.
- `CUBOS_POR_NIVEL`, 8: launches per speed-floor increment.
- `MAX_INTENTOS`, 8: rejection retries before the fallback mapping is used.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  game start button, level. Rising edge is used.
- `terminado_cubo`  in  1  cube finished (level or pulse), from `Cubo`.
- `posicion_x_inicial_aleatoria`  out  9  start column, registered.
- `velocidad_cubo`  out  2  fall speed, registered, never 0.
- `lanzar_cubo`  out  1  one-cycle launch strobe.
- `cubos_lanzados`  out  8  total launches, wraps 255→0.

## Operation

- LFSR: 16-bit Galois, taps mask 16'hB400, seed 16'hACE1. Advances every clock in every state, including IDLE. Never zero.
- `start_prev` register provides edge detection: `start & ~start_prev`.
- States:
  - IDLE: on start edge → SORTEO.
  - SORTEO: candidate `c = lfsr[8:0]`, range `R = X_MAX - X_MIN`.
    - If `c ≤ R`: accept, position = `X_MIN + c`.
    - Else, if the retry count has reached `MAX_INTENTOS`: position = `X_MIN + (c - (R+1))`. This is guaranteed ≤ `X_MAX` by the parameter constraint.
    - Else: increment the retry count and stay in SORTEO.
    - On accept (direct or fallback): load position and speed, clear the retry count → LANZAR.
  - LANZAR: `lanzar_cubo` = 1 (Moore output). Increment `cubos_lanzados` → ESPERA.
  - ESPERA: on `terminado_cubo` = 1 → SORTEO.
- Speed:
  - Raw `v = lfsr[10:9]`, with 0 mapped to 1.
  - Floor `nivel` starts at 1 and increments every `CUBOS_POR_NIVEL` launches, saturating at 3.
  - Output = `max(v, nivel)`.
  - The level counter is internal, 3 bits, and wraps every `CUBOS_POR_NIVEL` launches.
- Ignored inputs:
  - `start` outside IDLE.
  - `terminado_cubo` outside ESPERA (including when it coincides with LANZAR).
- Outputs hold their value between launches.

## Timing

- Reset (async, immediate):
  - State IDLE, LFSR = seed, `start_prev` = 0.
  - `posicion_x_inicial_aleatoria` = `X_MIN`, `velocidad_cubo` = 1.
  - `lanzar_cubo` = 0, `cubos_lanzados` = 0, `nivel` = 1, retry count = 0.
- Start edge sampled at edge k → SORTEO from k.
- Direct acceptance at edge k+1 → position and speed valid and `lanzar_cubo` high in the cycle after k+1.
- Worst-case start-to-strobe: `MAX_INTENTOS` + 2 edges.
- `terminado_cubo` sampled at edge j in ESPERA → next strobe no earlier than j+2.
- Position and speed change only on the SORTEO→LANZAR edge. They are stable for the whole strobe cycle and afterwards.
- Reset asserted mid-SORTEO or mid-ESPERA aborts the cycle. No strobe is issued until a new start edge.
- `start` held high continuously yields exactly one launch sequence. Restart requires reset.

## Structure

- Package `generador_cubos_pkg`: state enum (IDLE, SORTEO, LANZAR, ESPERA), `LFSR_SEED`, `LFSR_TAPS`, widths (`X_W` = 9, `V_W` = 2).
- Sub-module `lfsr16`: ports `clk`, `reset`, `q[15:0]`; free-running; reset to seed.
- FSM, speed floor and counters live in the top module.

## Test plan

- Reset, no start for 100 cycles → `posicion` = 16, `velocidad` = 1, `lanzar_cubo` never high, `cubos_lanzados` = 0.
- Start edge, then `terminado_cubo` pulsed 3 cycles after each strobe, 300 launches:
  - every position within 16..464;
  - `velocidad` ∈ 1..3;
  - every strobe exactly 1 cycle;
  - `cubos_lanzados` = 44 at the end (300 mod 256).
- Speed floor:
  - launches 9–16 all have `velocidad` ≥ 2;
  - launches 17 onward are all 3.
- Fallback, instance `X_MIN` = 0, `X_MAX` = 255, `MAX_INTENTOS` = 0: every position = `lfsr[8:0]` mod 256 and start-to-strobe is exactly 2 edges.
- `terminado_cubo` held high continuously → strobes every 3 cycles when accepted directly. `start` re-toggled during play → no extra strobes.
- Reset asserted during ESPERA after 5 launches → all outputs immediately at reset values. No strobe until a new start edge, after which `cubos_lanzados` counts from 1.
